// File: rtl/ddr_native_bram_responder.sv
// ddr_native_bram_responder: DDR native app-interface responder backed by on-chip RAM.
// Commands and write data meet through a small write-data FIFO. Reads return a fixed
// RD_LATENCY cycles after accept. Define DDR_NATIVE_RESPONDER_THROTTLE_EN to add
// LFSR-driven readiness throttling.
module ddr_native_bram_responder #(
  parameter int ADDR_WIDTH   = 27,
  parameter int DATA_WIDTH   = 256,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY   = 4,
  parameter int WDF_DEPTH    = 4
) (
  input  logic                    ui_clk,
  input  logic                    ui_rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete
);

  localparam int MASK_W    = DATA_WIDTH / 8;
  localparam int MEM_WORDS = 1 << MEM_AW;
  localparam int PTR_W     = $clog2(WDF_DEPTH);
  localparam int CNT_W     = $clog2(CALIB_CYCLES + 1);

  typedef enum logic {IDLE, WR_PEND} state_t;

  state_t                  state_q, state_d;
  logic [MEM_AW-1:0]       pendIdx_q, pendIdx_d;
  logic [CNT_W-1:0]        calibCnt_q;
  logic                    calibDone_q;
  logic [PTR_W:0]          wrPtr_q, rdPtr_q;
  logic [DATA_WIDTH-1:0]   fifoData_q [WDF_DEPTH];
  logic [MASK_W-1:0]       fifoMask_q [WDF_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
  logic [RD_LATENCY-1:0]   pipeValid_q;
  logic [DATA_WIDTH-1:0]   pipeData_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   rdData_q;
  logic                    rdValid_q;
  logic                    throttleCmd, throttleWdf;
  logic                    fifoEmpty, fifoFull;
  logic                    cmdAccept, readAccept, push, commit;
  logic [MEM_AW-1:0]       cmdIdx, commitIdx;
  logic [DATA_WIDTH-1:0]   headData;
  logic [MASK_W-1:0]       headMask;
  logic                    unusedBits;

  // Address bits outside the word index and the burst-end marker carry no meaning here.
  assign unusedBits = ^{app_wdf_end, app_addr[2:0], app_addr[ADDR_WIDTH-1:MEM_AW+3]};

`ifdef DDR_NATIVE_RESPONDER_THROTTLE_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that randomly withholds readiness.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign throttleCmd = lfsr_q[0];
  assign throttleWdf = lfsr_q[1];
`else
  assign throttleCmd = 1'b0;
  assign throttleWdf = 1'b0;
`endif

  // Calibration counter: completes after CALIB_CYCLES edges and then stays done until reset.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      calibCnt_q  <= '0;
      calibDone_q <= 1'b0;
    end else if (!calibDone_q) begin
      calibCnt_q <= calibCnt_q + CNT_W'(1);
      if (calibCnt_q == CNT_W'(CALIB_CYCLES - 1)) calibDone_q <= 1'b1;
    end
  end

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

  assign init_calib_complete = calibDone_q;
  assign app_rdy     = calibDone_q && (state_q == IDLE) && !throttleCmd;
  assign app_wdf_rdy = calibDone_q && !fifoFull && !throttleWdf;

  assign cmdAccept  = app_en && app_rdy;
  assign readAccept = cmdAccept && (app_cmd == 3'b001);
  assign push       = app_wdf_wren && app_wdf_rdy;
  assign cmdIdx     = app_addr[3 +: MEM_AW];
  assign headData   = fifoData_q[rdPtr_q[PTR_W-1:0]];
  assign headMask   = fifoMask_q[rdPtr_q[PTR_W-1:0]];

  // Write FSM: commit immediately when data is waiting, otherwise park in WR_PEND until it arrives.
  always_comb begin
    state_d   = state_q;
    pendIdx_d = pendIdx_q;
    commit    = 1'b0;
    commitIdx = cmdIdx;
    case (state_q)
      IDLE: begin
        if (cmdAccept && (app_cmd == 3'b000)) begin
          if (!fifoEmpty) begin
            commit = 1'b1;
          end else begin
            state_d   = WR_PEND;
            pendIdx_d = cmdIdx;
          end
        end
      end
      WR_PEND: begin
        if (!fifoEmpty) begin
          commit    = 1'b1;
          commitIdx = pendIdx_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with the latched index of a write that is still waiting for data.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q   <= IDLE;
      pendIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      pendIdx_q <= pendIdx_d;
    end
  end

  // FIFO pointers: one extra wrap bit distinguishes full from empty.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push)   wrPtr_q <= wrPtr_q + (PTR_W+1)'(1);
      if (commit) rdPtr_q <= rdPtr_q + (PTR_W+1)'(1);
    end
  end

  // FIFO storage holds data and mask side by side; contents need no reset.
  always_ff @(posedge ui_clk) begin
    if (push) begin
      fifoData_q[wrPtr_q[PTR_W-1:0]] <= app_wdf_data;
      fifoMask_q[wrPtr_q[PTR_W-1:0]] <= app_wdf_mask;
    end
  end

  // Backing memory: a commit writes only the byte lanes whose mask bit is clear.
  always_ff @(posedge ui_clk) begin
    if (commit) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!headMask[b]) mem_q[commitIdx][8*b +: 8] <= headData[8*b +: 8];
      end
    end
  end

  // Read pipeline snapshots the word at accept and delivers it RD_LATENCY edges later.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeData_q[i]  <= '0;
      end
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      pipeValid_q[0] <= readAccept;
      pipeData_q[0]  <= readAccept ? mem_q[cmdIdx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
      rdValid_q <= pipeValid_q[RD_LATENCY-1];
      rdData_q  <= pipeData_q[RD_LATENCY-1];
    end
  end

  assign app_rd_data       = rdData_q;
  assign app_rd_data_valid = rdValid_q;
  assign app_rd_data_end   = rdValid_q;

endmodule

// File: tb/tb_ddr_native_bram_responder.sv
// tb_ddr_native_bram_responder: directed bench for ddr_native_bram_responder with
// hand-computed expected values for calibration, writes, masking, FIFO and reset behaviour.
module tb_ddr_native_bram_responder;

  localparam int DW = 256;
  localparam int MW = 32;
  localparam int AW = 27;

  logic          ui_clk = 1'b0;
  logic          ui_rst = 1'b1;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = 3'b000;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;

  int   checkCount = 0;
  int   errorCount = 0;
  logic watchValid = 1'b0;
  int   validSeen  = 0;

  logic [DW-1:0] dataA5, dataFF, dataMasked, dataDead;
  logic [DW-1:0] beat0, beat1, beat2, beat3;
  logic          earlyRdy;

  ddr_native_bram_responder dut (
    .ui_clk              (ui_clk),
    .ui_rst              (ui_rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  always #5 ui_clk = ~ui_clk;

  // Counts read-data beats while a test has asked for them to be watched.
  always @(negedge ui_clk) begin
    if (watchValid && app_rd_data_valid) validSeen++;
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushBeat(input logic [DW-1:0] data, input logic [MW-1:0] mask);
    int waited = 0;
    app_wdf_data = data;
    app_wdf_mask = mask;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    while (!app_wdf_rdy && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("wdf_rdy_wait", app_wdf_rdy, 1);
    tick();
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  task automatic issueCmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    int waited = 0;
    app_cmd  = cmd;
    app_addr = addr;
    app_en   = 1'b1;
    while (!app_rdy && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("cmd_rdy_wait", app_rdy, 1);
    tick();
    app_en = 1'b0;
  endtask

  task automatic readCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expected, input string tag);
    issueCmd(3'b001, addr);
    tick();
    tick();
    tick();
    checkOutput({tag, "_early"}, app_rd_data_valid, 0);
    tick();
    checkOutput({tag, "_valid"}, app_rd_data_valid, 1);
    checkOutput({tag, "_end"}, app_rd_data_end, 1);
    checkOutput({tag, "_data"}, app_rd_data, expected);
    tick();
    checkOutput({tag, "_single"}, app_rd_data_valid, 0);
  endtask

  initial begin
    dataA5     = {32{8'hA5}};
    dataFF     = {32{8'hFF}};
    dataMasked = {{31{8'hFF}}, 8'h00};
    dataDead   = {8{32'hDEAD_BEEF}};
    beat0      = {32{8'h10}};
    beat1      = {32{8'h21}};
    beat2      = {32{8'h32}};
    beat3      = {32{8'h43}};

    // Reset state
    tick();
    tick();
    tick();
    checkOutput("rst_calib", init_calib_complete, 0);
    checkOutput("rst_rdy", app_rdy, 0);
    checkOutput("rst_wdf_rdy", app_wdf_rdy, 0);
    checkOutput("rst_valid", app_rd_data_valid, 0);
    checkOutput("rst_end", app_rd_data_end, 0);
    checkOutput("rst_data", app_rd_data, 0);

    // Calibration: complete exactly on the 64th edge after release
    ui_rst   = 1'b0;
    earlyRdy = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i < 64) earlyRdy = earlyRdy | init_calib_complete | app_rdy | app_wdf_rdy;
      if (i == 63) checkOutput("calib_edge63", init_calib_complete, 0);
    end
    checkOutput("calib_early_ready", earlyRdy, 0);
    checkOutput("calib_edge64", init_calib_complete, 1);
    checkOutput("calib_rdy", app_rdy, 1);
    checkOutput("calib_wdf_rdy", app_wdf_rdy, 1);

    // Write then read
    pushBeat(dataA5, '0);
    issueCmd(3'b000, 27'h08);
    readCheck(27'h08, dataA5, "wr_rd");

    // Byte mask: only lane 0 of the second write lands
    pushBeat(dataFF, '0);
    issueCmd(3'b000, 27'h10);
    pushBeat('0, 32'hFFFF_FFFE);
    issueCmd(3'b000, 27'h10);
    readCheck(27'h10, dataMasked, "mask");

    // Command before data parks in WR_PEND
    issueCmd(3'b000, 27'h10);
    checkOutput("pend_rdy_low", app_rdy, 0);
    pushBeat(dataDead, '0);
    checkOutput("pend_rdy_still_low", app_rdy, 0);
    tick();
    checkOutput("pend_rdy_release", app_rdy, 1);
    readCheck(27'h10, dataDead, "pend");

    // FIFO fill to full, then aliased write
    pushBeat(beat0, '0);
    pushBeat(beat1, '0);
    pushBeat(beat2, '0);
    checkOutput("fifo_three_rdy", app_wdf_rdy, 1);
    pushBeat(beat3, '0);
    checkOutput("fifo_full", app_wdf_rdy, 0);
    issueCmd(3'b000, 27'h10 + (27'd1024 << 3));
    checkOutput("fifo_after_pop", app_wdf_rdy, 1);
    readCheck(27'h10, beat0, "alias");
    issueCmd(3'b000, 27'h20);
    issueCmd(3'b000, 27'h28);
    issueCmd(3'b000, 27'h30);
    readCheck(27'h28, beat2, "fifo_order");

    // Unknown command code: accepted, no read data, memory untouched
    watchValid = 1'b1;
    validSeen  = 0;
    issueCmd(3'b010, 27'h08);
    for (int i = 0; i < 8; i++) tick();
    watchValid = 1'b0;
    checkOutput("othercmd_novalid", validSeen, 0);
    readCheck(27'h08, dataA5, "othercmd_mem");

    // Back-to-back reads return back-to-back in order
    issueCmd(3'b001, 27'h20);
    issueCmd(3'b001, 27'h28);
    issueCmd(3'b001, 27'h30);
    tick();
    checkOutput("b2b_gap", app_rd_data_valid, 0);
    tick();
    checkOutput("b2b_0_valid", app_rd_data_valid, 1);
    checkOutput("b2b_0_data", app_rd_data, beat1);
    tick();
    checkOutput("b2b_1_valid", app_rd_data_valid, 1);
    checkOutput("b2b_1_data", app_rd_data, beat2);
    tick();
    checkOutput("b2b_2_valid", app_rd_data_valid, 1);
    checkOutput("b2b_2_data", app_rd_data, beat3);
    tick();
    checkOutput("b2b_done", app_rd_data_valid, 0);

    // Reset mid-flight discards in-flight reads but keeps memory
    issueCmd(3'b001, 27'h08);
    issueCmd(3'b001, 27'h10);
    issueCmd(3'b001, 27'h28);
    watchValid = 1'b1;
    validSeen  = 0;
    ui_rst     = 1'b1;
    tick();
    tick();
    checkOutput("midrst_calib", init_calib_complete, 0);
    checkOutput("midrst_rdy", app_rdy, 0);
    ui_rst = 1'b0;
    for (int i = 0; i < 200 && !init_calib_complete; i++) tick();
    checkOutput("midrst_recal", init_calib_complete, 1);
    for (int i = 0; i < 6; i++) tick();
    watchValid = 1'b0;
    checkOutput("midrst_no_valid", validSeen, 0);
    readCheck(27'h08, dataA5, "midrst_mem_a");
    readCheck(27'h30, beat3, "midrst_mem_b");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ddr_native_bram_responder.md
DDR_NATIVE_BRAM_RESPONDER -- requirements
Module: ddr_native_bram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 27: width of app_addr.
REQ-002 Parameter DATA_WIDTH, default 256: width of app_wdf_data and app_rd_data; mask width is DATA_WIDTH/8.
REQ-003 Parameter MEM_AW, default 10: log2 of the number of DATA_WIDTH words in the backing memory.
REQ-004 Parameter CALIB_CYCLES, default 64: number of cycles after reset before calibration completes.
REQ-005 Parameter RD_LATENCY, default 4: cycles from read-command accept to app_rd_data_valid, legal range 1..16.
REQ-006 Parameter WDF_DEPTH, default 4: entries in the write-data FIFO, power of two, at least 2.
REQ-007 Port ui_clk, input, 1: single clock for all logic.
REQ-008 Port ui_rst, input, 1: reset, asynchronous, active-high.
REQ-009 Port app_addr, input, ADDR_WIDTH: command address.
REQ-010 Port app_cmd, input, 3: 3'b000 is write, 3'b001 is read.
REQ-011 Port app_en, input, 1: command valid.
REQ-012 Port app_rdy, output, 1: command ready.
REQ-013 Ports app_wdf_data (DATA_WIDTH), app_wdf_mask (DATA_WIDTH/8), app_wdf_wren (1) and app_wdf_end (1) are inputs carrying write data.
REQ-014 Port app_wdf_rdy, output, 1: write-data ready.
REQ-015 Ports app_rd_data (DATA_WIDTH), app_rd_data_valid (1) and app_rd_data_end (1) are outputs carrying read data.
REQ-016 Port init_calib_complete, output, 1: memory usable.

Function
REQ-017 A calibration counter SHALL hold init_calib_complete at 0 for CALIB_CYCLES cycles after reset release and SHALL then hold it at 1 until the next reset.
REQ-018 app_rdy and app_wdf_rdy SHALL be 0 while init_calib_complete is 0.
REQ-019 A command SHALL be accepted on a rising edge where app_en and app_rdy are both 1; commands with no accept are never observed.
REQ-020 A write beat SHALL be pushed into the write-data FIFO (data plus mask) on a rising edge where app_wdf_wren and app_wdf_rdy are both 1.
REQ-021 app_wdf_end SHALL be ignored; each command consumes exactly one beat.
REQ-022 app_wdf_rdy SHALL be 0 when the FIFO is full.
REQ-023 A simultaneous push and pop on a full FIFO SHALL NOT be allowed; app_wdf_rdy stays 0 in that case.
REQ-024 Write data MAY precede its command by up to WDF_DEPTH beats.
REQ-025 The memory word index SHALL be app_addr[3 +: MEM_AW].
REQ-026 The low 3 address bits SHALL be ignored, and higher address bits SHALL alias, so addresses wrap modulo 2^MEM_AW words.
REQ-027 An accepted write SHALL commit on the same edge if the FIFO is non-empty before that edge's push; commit pops the head entry.
REQ-028 If the FIFO is empty when a write is accepted, the block SHALL enter state WR_PEND with the index latched, and SHALL commit and return to IDLE on the first edge the FIFO is non-empty.
REQ-029 app_rdy SHALL be 0 in WR_PEND.
REQ-030 On commit, a byte lane SHALL be written only where its app_wdf_mask bit is 0.
REQ-031 An accepted read SHALL return the memory word on app_rd_data exactly RD_LATENCY cycles later, with app_rd_data_valid and app_rd_data_end both 1 for that single cycle.
REQ-032 There SHALL be no read-data backpressure; back-to-back reads return back-to-back in order.
REQ-033 A read accepted on the same edge as, or after, a write commit SHALL observe the committed data.
REQ-034 Commands with any other app_cmd code SHALL be accepted with no memory or read-data effect.

Reset
REQ-035 Reset SHALL clear to 0: app_rdy, app_wdf_rdy, init_calib_complete, app_rd_data_valid, app_rd_data_end, app_rd_data, the calibration counter, FIFO pointers, the read pipeline and the state (to IDLE).
REQ-036 A reset asserted mid-operation SHALL discard in-flight reads, the pending write and buffered write data.
REQ-037 Reset SHALL NOT clear memory contents.

Configuration
REQ-038 With DDR_NATIVE_RESPONDER_THROTTLE_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advancing every cycle SHALL force app_rdy to 0 when bit0 is 1 and app_wdf_rdy to 0 when bit1 is 1, in addition to the other conditions.
REQ-039 With DDR_NATIVE_RESPONDER_THROTTLE_EN undefined, no LFSR SHALL exist, and readiness SHALL depend only on calibration, FIFO and state.

Verification
REQ-040 Calibration: release reset with CALIB_CYCLES=64 -> init_calib_complete rises on cycle 64; app_rdy and app_wdf_rdy are 0 before that cycle.
REQ-041 Write then read: push data 256'hA5..A5 with mask 0, write cmd addr 0x08, then read cmd addr 0x08 -> valid and end both 1 four cycles after the read accept, data A5..A5.
REQ-042 Byte mask: write all-FF to index 2, then write all-00 with mask 32'hFFFF_FFFE -> reading index 2 returns FF..FF00.
REQ-043 Command before data: write cmd addr 0x10 with the FIFO empty -> app_rdy falls the next cycle; a data push then commits and app_rdy rises; a read returns the pushed data.
REQ-044 FIFO full and alias: push 4 beats with no commands -> app_wdf_rdy is 0; a write to addr 0x10 + (1024<<3) is then readable at addr 0x10.
REQ-045 Reset mid-flight: issue 3 reads, assert ui_rst before any returns -> no app_rd_data_valid is ever seen; data written earlier is still readable after recalibration.
